afifo_rd_prefetch: RTL and testbench



---
 rtl/afifo_pkg.sv | 21 ++
 rtl/afifo_rd_buf.sv | 64 ++++++
 rtl/afifo_rd_prefetch.sv | 80 ++++++++
 tb/tb_afifo_rd_prefetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO read-side blocks: word width default
// and the sizing helpers used by the read prefetch stage.
package afifo_pkg;

    localparam int AFIFO_DATA_W = 32;

    // Only one- and two-cycle SRAM read latencies are supported by the tracker.
    function automatic bit ram_lat_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    // One entry per in-flight read plus two so the stream can run at full rate.
    function automatic int rd_buf_depth(input int lat);
        return lat + 2;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/afifo_rd_buf.sv
// Circular holding buffer for the read prefetch stage. Depth need not be a
// power of two, so both pointers wrap explicitly.
module afifo_rd_buf
    import afifo_pkg::*;
#(
    parameter int DATA_W = AFIFO_DATA_W,
    parameter int DEPTH  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            push,
    input  logic [DATA_W-1:0]               wdata,
    input  logic                            pop,
    output logic [DATA_W-1:0]               rdata,
    output logic                            valid,
    output logic [level_width(DEPTH)-1:0]   level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = level_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid  = (level != '0);
    assign do_pop = pop & valid;
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/afifo_rd_prefetch.sv
// Read-side prefetch stage: issues FIFO reads against a credit limit, tracks
// reads in flight through the SRAM, and streams the returned words out.
module afifo_rd_prefetch
    import afifo_pkg::*;
#(
    parameter int DATA_W    = AFIFO_DATA_W,
    parameter int RAM_LAT   = 1,
    parameter int BUF_DEPTH = rd_buf_depth(RAM_LAT)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              fifo_empty,
    output logic                              fifo_inc,
    input  logic [DATA_W-1:0]                 fifo_rdata,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]    level
);

    localparam int LVL_W = level_width(BUF_DEPTH);

    if (!ram_lat_legal(RAM_LAT)) begin : g_bad_lat
        $error("afifo_rd_prefetch: RAM_LAT must be 1 or 2");
    end
    if (BUF_DEPTH != rd_buf_depth(RAM_LAT)) begin : g_bad_depth
        $error("afifo_rd_prefetch: BUF_DEPTH is derived from RAM_LAT");
    end

    logic [RAM_LAT-1:0] trk;
    logic [LVL_W-1:0]   inflight;
    logic [LVL_W:0]     used;
    logic               capture;
    logic               pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LAT; i++) begin
            inflight = inflight + LVL_W'(trk[i]);
        end
    end

    // Credit covers words already buffered plus words still inside the SRAM,
    // so every issued read has a slot waiting when it lands.
    assign used     = {1'b0, level} + {1'b0, inflight};
    assign fifo_inc = rst_n & ~clear & ~fifo_empty & (used < (LVL_W+1)'(BUF_DEPTH));
    assign capture  = trk[RAM_LAT-1];

    // Stream handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready is low,
    // out_valid and out_data stay stable.
    assign pop = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk <= '0;
        end else if (clear) begin
            trk <= '0;
        end else begin
            trk <= RAM_LAT'({trk, fifo_inc});
        end
    end

    afifo_rd_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (capture),
        .wdata (fifo_rdata),
        .pop   (pop),
        .rdata (out_data),
        .valid (out_valid),
        .level (level)
    );

endmodule

// File: tb/tb_afifo_rd_prefetch.sv
// Bench for afifo_rd_prefetch: runs a RAM_LAT=1 and a RAM_LAT=2 instance side
// by side against a transaction-level model of the FIFO, SRAM and stream.
module tb_afifo_rd_prefetch;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    logic            out_ready;
    logic [1:0]      fifo_empty;
    logic [1:0]      fifo_inc;
    logic [1:0]      out_valid;
    logic [DW-1:0]   fifo_rdata [2];
    logic [DW-1:0]   out_data [2];
    logic [1:0]      lvl0;
    logic [2:0]      lvl1;
    logic [2:0]      level_a [2];

    assign level_a[0] = {1'b0, lvl0};
    assign level_a[1] = lvl1;

    afifo_rd_prefetch #(.DATA_W(DW), .RAM_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .fifo_empty(fifo_empty[0]), .fifo_inc(fifo_inc[0]), .fifo_rdata(fifo_rdata[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .level(lvl0)
    );

    afifo_rd_prefetch #(.DATA_W(DW), .RAM_LAT(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .fifo_empty(fifo_empty[1]), .fifo_inc(fifo_inc[1]), .fifo_rdata(fifo_rdata[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .level(lvl1)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model state ----------------
    logic [DW-1:0] src_mem [0:1023];
    int            src_wr;
    int            src_rd [2];
    logic [DW-1:0] exp_q [2][$];
    int            iss_q [2][$];
    logic [DW-1:0] pipe [2][2];
    int            cyc;
    int            beats [2];
    int            incs [2];
    int            max_lvl [2];
    int            first_inc [2];
    int            first_val [2];
    int            last_beat [2];
    int            checks;
    int            failures;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_flush();
        for (int l = 0; l < 2; l++) begin
            exp_q[l].delete();
            iss_q[l].delete();
            src_rd[l] = src_wr;
        end
    endtask

    task automatic clear_stats();
        for (int l = 0; l < 2; l++) begin
            beats[l]     = 0;
            incs[l]      = 0;
            max_lvl[l]   = 0;
            first_inc[l] = -1;
            first_val[l] = -1;
            last_beat[l] = -1;
        end
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        src_mem[src_wr] = w;
        src_wr++;
    endtask

    // Checks one lane against the model, then advances the model past the edge.
    task automatic lane_step(input int l, input bit rdy, input bit clr, input bit rst_v);
        int lat;
        int depth;
        int lvl_exp;
        bit v_exp;
        bit inc_exp;
        logic [DW-1:0] w;
        lat   = l + 1;
        depth = lat + 2;
        lvl_exp = 0;
        foreach (iss_q[l][i]) begin
            if (iss_q[l][i] <= cyc - lat - 1) lvl_exp++;
        end
        v_exp   = (lvl_exp != 0);
        inc_exp = rst_v && !clr && !fifo_empty[l] && (exp_q[l].size() < depth);

        check($sformatf("l%0d_inc", l), 64'(fifo_inc[l]), 64'(inc_exp));
        check($sformatf("l%0d_valid", l), 64'(out_valid[l]), 64'(v_exp));
        check($sformatf("l%0d_level", l), 64'(level_a[l]), 64'(lvl_exp));
        if (v_exp) check($sformatf("l%0d_data", l), 64'(out_data[l]), 64'(exp_q[l][0]));

        if (fifo_inc[l]) begin
            incs[l]++;
            if (first_inc[l] < 0) first_inc[l] = cyc;
        end
        if (out_valid[l] && first_val[l] < 0) first_val[l] = cyc;
        if (out_valid[l] && rdy) begin
            beats[l]++;
            last_beat[l] = cyc;
        end
        if (int'(level_a[l]) > max_lvl[l]) max_lvl[l] = int'(level_a[l]);

        if (v_exp && rdy) begin
            void'(exp_q[l].pop_front());
            void'(iss_q[l].pop_front());
        end
        pipe[l][1] = pipe[l][0];
        if (fifo_inc[l] && src_rd[l] != src_wr) begin
            w = src_mem[src_rd[l]];
            src_rd[l]++;
            exp_q[l].push_back(w);
            iss_q[l].push_back(cyc);
            pipe[l][0] = w;
        end else begin
            pipe[l][0] = $urandom;
        end
        if (clr) begin
            exp_q[l].delete();
            iss_q[l].delete();
            src_rd[l] = src_wr;
        end
    endtask

    // Driver: one clock cycle with the given stream/control inputs.
    task automatic cycle(input bit rdy, input bit clr, input bit rst_v);
        @(negedge clk);
        rst_n     = rst_v;
        clear     = clr;
        out_ready = rdy;
        if (!rst_v) model_flush();
        for (int l = 0; l < 2; l++) begin
            fifo_empty[l] = (src_rd[l] == src_wr);
            fifo_rdata[l] = pipe[l][l];
        end
        #1;
        for (int l = 0; l < 2; l++) lane_step(l, rdy, clr, rst_v);
        cyc++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit timed_out;
        int written;
        int k;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        src_wr    = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        fifo_empty = 2'b11;
        for (int l = 0; l < 2; l++) begin
            src_rd[l]     = 0;
            fifo_rdata[l] = '0;
            pipe[l][0]    = '0;
            pipe[l][1]    = '0;
        end
        clear_stats();

        // Reset state
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("rst_l%0d_data", l), 64'(out_data[l]), 64'h0);
            check($sformatf("rst_l%0d_level", l), 64'(level_a[l]), 64'h0);
        end
        cycle(1'b1, 1'b0, 1'b1);

        // Preloaded FIFO, full-rate streaming
        clear_stats();
        for (int i = 0; i < 8; i++) write_word(DW'(32'h10 + i));
        repeat (16) cycle(1'b1, 1'b0, 1'b1);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("s1_l%0d_latency", l), 64'(first_val[l] - first_inc[l]), 64'(l + 2));
            check($sformatf("s1_l%0d_beats", l), 64'(beats[l]), 64'd8);
            check($sformatf("s1_l%0d_back2back", l), 64'(last_beat[l] - first_val[l]), 64'd7);
        end

        // Back-pressure fills the buffer, then drains in order
        clear_stats();
        for (int i = 0; i < 10; i++) write_word(DW'(32'h10 + i));
        repeat (8) cycle(1'b0, 1'b0, 1'b1);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("s2_l%0d_issued", l), 64'(incs[l]), 64'(l + 3));
            check($sformatf("s2_l%0d_level", l), 64'(level_a[l]), 64'(l + 3));
            check($sformatf("s2_l%0d_hold", l), 64'(out_data[l]), 64'h10);
        end
        repeat (24) cycle(1'b1, 1'b0, 1'b1);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("s2_l%0d_beats", l), 64'(beats[l]), 64'd10);
        end

        // Random words arriving over time, out_ready toggling
        clear_stats();
        written   = 0;
        k         = 0;
        timed_out = 1'b0;
        while (written < 20 || exp_q[0].size() != 0 || exp_q[1].size() != 0
               || src_rd[0] != src_wr || src_rd[1] != src_wr) begin
            if (written < 20 && $urandom_range(0, 3) != 0) begin
                write_word($urandom);
                written++;
            end
            cycle((k % 2) == 0, 1'b0, 1'b1);
            k++;
            if (k >= 400) begin
                timed_out = 1'b1;
                break;
            end
        end
        check("s3_timeout", 64'(timed_out), 64'd0);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("s3_l%0d_beats", l), 64'(beats[l]), 64'd20);
            check($sformatf("s3_l%0d_maxlvl_ok", l), 64'(max_lvl[l] <= l + 3), 64'd1);
        end

        // Clear with one read in flight
        clear_stats();
        write_word(32'h0000_00a5);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (6) cycle(1'b1, 1'b0, 1'b1);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("s4_l%0d_issued", l), 64'(incs[l]), 64'd1);
            check($sformatf("s4_l%0d_beats", l), 64'(beats[l]), 64'd0);
        end

        // Empty FIFO idles, then a single word
        clear_stats();
        repeat (5) cycle(1'b1, 1'b0, 1'b1);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("s5_l%0d_idle_inc", l), 64'(incs[l]), 64'd0);
            check($sformatf("s5_l%0d_idle_val", l), 64'(first_val[l]), 64'hffff_ffff_ffff_ffff);
        end
        write_word($urandom);
        repeat (8) cycle(1'b1, 1'b0, 1'b1);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("s5_l%0d_beats", l), 64'(beats[l]), 64'd1);
        end

        // Asynchronous reset with two words buffered
        clear_stats();
        write_word(32'h0000_0c01);
        write_word(32'h0000_0c02);
        repeat (6) cycle(1'b0, 1'b0, 1'b1);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("s6_l%0d_level", l), 64'(level_a[l]), 64'd2);
        end
        #2;
        rst_n = 1'b0;
        model_flush();
        #1;
        for (int l = 0; l < 2; l++) begin
            check($sformatf("s6_l%0d_async_valid", l), 64'(out_valid[l]), 64'd0);
            check($sformatf("s6_l%0d_async_level", l), 64'(level_a[l]), 64'd0);
            check($sformatf("s6_l%0d_async_inc", l), 64'(fifo_inc[l]), 64'd0);
        end
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        clear_stats();
        repeat (8) cycle(1'b1, 1'b0, 1'b1);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("s6_l%0d_stale", l), 64'(beats[l]), 64'd0);
        end

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
